// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM state encodings and op decode for the HI/LO multiply/divide unit.
// MADD/MADDU decode is always present; whether they execute is decided in the top (MUL_DIV_MADD_EN).
package mul_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_MADD  = 3'd6;
    localparam logic [2:0] MD_MADDU = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    typedef struct packed {
        logic mul;
        logic div;
        logic sgn;
        logic madd;
    } md_dec_t;

    function automatic md_dec_t md_decode(input logic [2:0] op);
        md_dec_t d;
        d = md_dec_t'(4'b0000);
        case (op)
            MD_MULT:  begin d.mul = 1'b1; d.sgn = 1'b1; end
            MD_MULTU: begin d.mul = 1'b1; end
            MD_DIV:   begin d.div = 1'b1; d.sgn = 1'b1; end
            MD_DIVU:  begin d.div = 1'b1; end
            MD_MADD:  begin d.mul = 1'b1; d.sgn = 1'b1; d.madd = 1'b1; end
            MD_MADDU: begin d.mul = 1'b1; d.madd = 1'b1; end
            default:  begin d = md_dec_t'(4'b0000); end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface mul_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, opA, opB, flush, input busy, done, hi, lo);
    modport slave  (input start, op, opA, opB, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_sign.sv
// Combinational sign handling: operand magnitudes going in, two's-complement correction
// of the unsigned product / quotient / remainder coming out.
module mul_div_sign #(
    parameter int WIDTH = 32
) (
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic                 a_neg,
    output logic                 b_neg,
    input  logic                 res_neg,
    input  logic                 rem_neg,
    input  logic [2*WIDTH-1:0]   prod_raw,
    input  logic [WIDTH-1:0]     quo_raw,
    input  logic [WIDTH-1:0]     rem_raw,
    output logic [2*WIDTH-1:0]   prod_out,
    output logic [WIDTH-1:0]     quo_out,
    output logic [WIDTH-1:0]     rem_out
);

    // Most-negative input negates to itself, which read unsigned is the correct magnitude.
    always_comb begin
        a_neg    = signed_op & a[WIDTH-1];
        b_neg    = signed_op & b[WIDTH-1];
        a_mag    = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag    = b_neg ? (~b + WIDTH'(1)) : b;
        prod_out = res_neg ? (~prod_raw + (2*WIDTH)'(1)) : prod_raw;
        quo_out  = res_neg ? (~quo_raw + WIDTH'(1)) : quo_raw;
        rem_out  = rem_neg ? (~rem_raw + WIDTH'(1)) : rem_raw;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit owning HI/LO (IDLE -> CALC x WIDTH -> FIX).
// Optional MUL_DIV_MADD_EN enables MADD/MADDU accumulation into {HI,LO}; otherwise they are no-ops.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);

    localparam int              CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  p_q, p_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic                div_zero_q, div_zero_d;
`ifdef MUL_DIV_MADD_EN
    logic                madd_q, madd_d;
`endif
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;

    md_dec_t             dec_s;
    logic                multi_s;
    logic [WIDTH-1:0]    a_mag_s, b_mag_s;
    logic                a_neg_s, b_neg_s;
    logic [WIDTH:0]      add_s, rsh_s;
    logic [WIDTH-1:0]    sub_s;
    logic [2*WIDTH-1:0]  mul_step_s, div_step_s, prod_fix_s, acc_s;
    logic [WIDTH-1:0]    quo_fix_s, rem_fix_s;

    mul_div_sign #(.WIDTH(WIDTH)) u_sign (
        .signed_op (dec_s.sgn),
        .a         (bus.opA),
        .b         (bus.opB),
        .a_mag     (a_mag_s),
        .b_mag     (b_mag_s),
        .a_neg     (a_neg_s),
        .b_neg     (b_neg_s),
        .res_neg   (neg_q),
        .rem_neg   (rem_neg_q),
        .prod_raw  (p_q),
        .quo_raw   (p_q[WIDTH-1:0]),
        .rem_raw   (p_q[2*WIDTH-1:WIDTH]),
        .prod_out  (prod_fix_s),
        .quo_out   (quo_fix_s),
        .rem_out   (rem_fix_s)
    );

    // Decode the incoming op and decide whether it needs the iterative datapath.
    always_comb begin
        dec_s = md_decode(bus.op);
`ifdef MUL_DIV_MADD_EN
        multi_s = dec_s.mul | dec_s.div;
`else
        multi_s = (dec_s.mul & ~dec_s.madd) | dec_s.div;
`endif
    end

    // One iteration of both datapaths; p_q holds {acc/rem, multiplier/quotient}.
    always_comb begin
        add_s      = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_step_s = {add_s, p_q[WIDTH-1:1]};
        rsh_s      = p_q[2*WIDTH-1:WIDTH-1];
        sub_s      = rsh_s[WIDTH-1:0] - b_q;
        if (rsh_s >= {1'b0, b_q}) begin
            div_step_s = {sub_s, p_q[WIDTH-2:0], 1'b1};
        end else begin
            div_step_s = {rsh_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end
`ifdef MUL_DIV_MADD_EN
        acc_s = madd_q ? ({hi_q, lo_q} + prod_fix_s) : prod_fix_s;
`else
        acc_s = prod_fix_s;
`endif
    end

    // Control FSM: accept, iterate, then correct signs and commit HI/LO.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        b_d        = b_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
`ifdef MUL_DIV_MADD_EN
        madd_d     = madd_q;
`endif
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !bus.flush) begin
                    if (multi_s) begin
                        state_d    = ST_CALC;
                        cnt_d      = {CNT_W{1'b0}};
                        p_d        = {{WIDTH{1'b0}}, a_mag_s};
                        b_d        = b_mag_s;
                        is_div_d   = dec_s.div;
                        neg_d      = a_neg_s ^ b_neg_s;
                        rem_neg_d  = a_neg_s;
                        div_zero_d = (bus.opB == {WIDTH{1'b0}});
`ifdef MUL_DIV_MADD_EN
                        madd_d     = dec_s.madd;
`endif
                        busy_d     = 1'b1;
                    end else if (bus.op == MD_MTHI) begin
                        hi_d = bus.opA;
                    end else if (bus.op == MD_MTLO) begin
                        lo_d = bus.opA;
                    end else begin
                        busy_d = 1'b0;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    p_d   = is_div_q ? div_step_s : mul_step_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
                if (bus.flush) begin
                    done_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                    // Divide by zero: iteration leaves |opA| as remainder, so hi reconstructs opA.
                    if (is_div_q) begin
                        hi_d = rem_fix_s;
                        lo_d = div_zero_q ? {WIDTH{1'b1}} : quo_fix_s;
                    end else begin
                        {hi_d, lo_d} = acc_s;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            p_q        <= {(2*WIDTH){1'b0}};
            b_q        <= {WIDTH{1'b0}};
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef MUL_DIV_MADD_EN
            madd_q     <= 1'b0;
`endif
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            b_q        <= b_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
`ifdef MUL_DIV_MADD_EN
            madd_q     <= madd_d;
`endif
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model, per-cycle compare, directed
// and random stimulus. MADD/MADDU expectations follow MUL_DIV_MADD_EN.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit is_multi(input logic [2:0] op);
`ifdef MUL_DIV_MADD_EN
        return (op != MD_MTHI) && (op != MD_MTLO);
`else
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`endif
    endfunction

    // Returns {hi, lo} after a multi-cycle op with the given operands and prior HI/LO.
    function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        longint     sa, sb;
        logic [63:0] p;
        int         qi, ri;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (op)
            MD_MULT:  p = 64'(sa * sb);
            MD_MULTU: p = {32'd0, a} * {32'd0, b};
            MD_MADD:  p = {hi, lo} + 64'(sa * sb);
            MD_MADDU: p = {hi, lo} + ({32'd0, a} * {32'd0, b});
            MD_DIV: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else begin
                    qi = $signed(a) / $signed(b);
                    ri = $signed(a) % $signed(b);
                    p  = {32'(ri), 32'(qi)};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = {hi, lo};
        endcase
        return p;
    endfunction

    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [2:0]  m_op;
    int          m_left;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_hi <= 32'd0; m_lo <= 32'd0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (bus.flush) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_hi, m_lo} <= md_model(m_op, m_a, m_b, m_hi, m_lo);
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (bus.start && !bus.flush) begin
                if (is_multi(bus.op)) begin
                    m_busy <= 1'b1; m_left <= W + 1;
                    m_op <= bus.op; m_a <= bus.opA; m_b <= bus.opB;
                end else if (bus.op == MD_MTHI) begin
                    m_hi <= bus.opA;
                end else if (bus.op == MD_MTLO) begin
                    m_lo <= bus.opA;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    bit chk_en;

    // One clock: active edge, then compare DUT against the model on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (chk_en) begin
            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_done);
            check("hi",   bus.hi,   m_hi);
            check("lo",   bus.lo,   m_lo);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.opA = a; bus.opB = b;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.done !== 1'b1 && n < budget);
        check("done_within_budget", bus.done, 1'b1);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'($urandom_range(0, 20));
            5: begin v = 32'($urandom_range(1, 20)); v = 32'd0 - v; end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    int n, nd;

    initial begin
        n_checks = 0; n_pass = 0; chk_en = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.opA = 32'd0; bus.opB = 32'd0; bus.flush = 1'b0;

        // Pin the model against hand-computed results.
        check("model_multu", md_model(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0), 64'hFFFF_FFFE_0000_0001);
        check("model_mult",  md_model(MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0), 64'hFFFF_FFFF_FFFF_FFF1);
        check("model_divu",  md_model(MD_DIVU, 32'd7, 32'd2, 32'd0, 32'd0), 64'h0000_0001_0000_0003);
        check("model_div",   md_model(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_ovf",   md_model(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0), 64'h0000_0000_8000_0000);
        check("model_div0",  md_model(MD_DIV, 32'h0000_1234, 32'd0, 32'd0, 32'd0), 64'h0000_1234_FFFF_FFFF);
        check("model_maddu", md_model(MD_MADDU, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1), 64'h0000_0001_FFFF_FFFF);

        tick(); chk_en = 1'b1; tick();
        reset = 1'b0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);

        // Full-range unsigned multiply with latency.
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy", bus.busy, 1'b1);
        wait_done(60, n);
        check("multu_latency", 64'(n), 64'd33);
        check("multu_busy_in_done", bus.busy, 1'b0);
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);

        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5); wait_done(60, n);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFF1);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2); wait_done(60, n);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(60, n);
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'd0);

        // Divide by zero, a start while busy, and a start in the done cycle.
        issue(MD_DIV, 32'h0000_1234, 32'd0);
        tick(); tick(); tick();
        issue(MD_MULTU, 32'd9, 32'd9);
        check("ignored_start_busy", bus.busy, 1'b1);
        wait_done(60, n);
        check("div0_latency", 64'(n), 64'd29);
        check("div0_lo", bus.lo, 32'hFFFF_FFFF);
        check("div0_hi", bus.hi, 32'h0000_1234);
        issue(MD_DIVU, 32'd7, 32'd2);
        check("done_cycle_accept", bus.busy, 1'b1);
        wait_done(60, n);
        check("divu_lo", bus.lo, 32'd3);
        check("divu_hi", bus.hi, 32'd1);

        // MTHI/MTLO then a flushed MULT.
        issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi_busy", bus.busy, 1'b0);
        issue(MD_MTLO, 32'h0000_BEEF, 32'd0);
        check("mtlo_lo", bus.lo, 32'h0000_BEEF);
        check("mtlo_done", bus.done, 1'b0);
        issue(MD_MULT, 32'd3, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        check("flush_busy", bus.busy, 1'b0);
        check("flush_hi", bus.hi, 32'hDEAD_BEEF);
        check("flush_lo", bus.lo, 32'h0000_BEEF);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) nd++;
        end
        check("flush_no_done", 64'(nd), 64'd0);

        // Reset in the middle of CALC.
        issue(MD_MULT, 32'd5, 32'd5);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);

        // MADDU: accumulate when enabled, no-op otherwise.
        issue(MD_MTLO, 32'd1, 32'd0);
        issue(MD_MADDU, 32'hFFFF_FFFF, 32'd2);
`ifdef MUL_DIV_MADD_EN
        wait_done(60, n);
        check("maddu_hi", bus.hi, 32'd1);
        check("maddu_lo", bus.lo, 32'hFFFF_FFFF);
`else
        check("maddu_nop_busy", bus.busy, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        check("maddu_nop_hi", bus.hi, 32'd0);
        check("maddu_nop_lo", bus.lo, 32'd1);
`endif

        // Random traffic; the per-cycle compare does the checking.
        for (int c = 0; c < 6000; c++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 3'($urandom_range(0, 7));
            bus.opA   = rand_operand();
            bus.opB   = rand_operand();
            bus.flush = ($urandom_range(0, 149) == 0);
            reset     = ($urandom_range(0, 1999) == 0);
            tick();
        end
        bus.start = 1'b0; bus.flush = 1'b0; reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
